// File: rtl/seqstream_pkg.sv
// Shared types and default widths for the seqstream sequence generator.
// The command record and the two-state controller enum live here.
package seqstream_pkg;

    localparam int WWIDTH_DEF  = 8;
    localparam int CWIDTH_DEF  = 4;
    localparam int QDEPTH_DEF  = 2;
    localparam int QIWIDTH_DEF = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // One queued command at the default widths; a count of 0 encodes 2^CWIDTH.
    typedef struct packed {
        logic [WWIDTH_DEF-1:0] start;
        logic [WWIDTH_DEF-1:0] stride;
        logic [CWIDTH_DEF-1:0] count;
    } cmd_t;

endpackage

// File: rtl/seqcmd_fifo.sv
// Synchronous command FIFO with full/empty flags; pointers carry one wrap bit.
// Pushes while full and pops while empty are ignored.
module seqcmd_fifo #(
    parameter int WIDTH  = 20,
    parameter int DEPTH  = 2,
    parameter int IWIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [IWIDTH:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IWIDTH:0]  wr_ptr_q;
    logic [IWIDTH:0]  rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[IWIDTH] != rd_ptr_q[IWIDTH]) &&
                     (wr_ptr_q[IWIDTH-1:0] == rd_ptr_q[IWIDTH-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q[IWIDTH-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (!rst_i && do_push) mem_q[wr_ptr_q[IWIDTH-1:0]] <= data_i;
    end

endmodule

// File: rtl/seqstream.sv
// Arithmetic sequence streamer: queued (start, stride, count) commands become
// element streams. Define SEQSTREAM_SATURATE_EN for unsigned clamping instead of wrap.
module seqstream
    import seqstream_pkg::*;
#(
    parameter int WWIDTH  = WWIDTH_DEF,
    parameter int CWIDTH  = CWIDTH_DEF,
    parameter int QDEPTH  = QDEPTH_DEF,
    parameter int QIWIDTH = QIWIDTH_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LoadValid,
    output logic              LoadReady,
    input  logic [WWIDTH-1:0] Start,
    input  logic [WWIDTH-1:0] Stride,
    input  logic [CWIDTH-1:0] Count,
    output logic [WWIDTH-1:0] DataOut,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              OutLast,
    output logic              IsFull,
    output logic              IsEmpty,
    output logic              DbgState
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and the offered data holds until taken.

    localparam int CMDW = 2 * WWIDTH + CWIDTH;
    localparam logic [CWIDTH:0] REMAIN_ONE = 1;
    localparam logic [CWIDTH:0] FULL_COUNT = {1'b1, {CWIDTH{1'b0}}};

    typedef struct packed {
        logic [WWIDTH-1:0] start;
        logic [WWIDTH-1:0] stride;
        logic [CWIDTH-1:0] count;
    } cmd_w_t;

    cmd_w_t            load_cmd;
    cmd_w_t            head_cmd;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              is_last;

    state_t            state_q, state_d;
    logic [WWIDTH-1:0] data_q, data_d;
    logic [WWIDTH-1:0] stride_q, stride_d;
    logic [CWIDTH:0]   remain_q, remain_d;

    function automatic logic [WWIDTH-1:0] next_elem(input logic [WWIDTH-1:0] cur,
                                                    input logic [WWIDTH-1:0] step);
`ifdef SEQSTREAM_SATURATE_EN
        logic [WWIDTH+1:0] sum;
        // Two guard bits: top bit flags underflow below 0, next flags overflow.
        sum = {2'b00, cur} + {{2{step[WWIDTH-1]}}, step};
        if (sum[WWIDTH+1])   return '0;
        else if (sum[WWIDTH]) return '1;
        else                 return sum[WWIDTH-1:0];
`else
        return cur + step;
`endif
    endfunction

    assign load_cmd = {Start, Stride, Count};

    seqcmd_fifo #(
        .WIDTH  (CMDW),
        .DEPTH  (QDEPTH),
        .IWIDTH (QIWIDTH)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .push_i  (LoadValid),
        .data_i  (load_cmd),
        .pop_i   (fifo_pop),
        .data_o  (head_cmd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign is_last = (remain_q == REMAIN_ONE);

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        stride_d = stride_q;
        remain_d = remain_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_RUN;
                    data_d   = head_cmd.start;
                    stride_d = head_cmd.stride;
                    remain_d = (head_cmd.count == '0) ? FULL_COUNT : {1'b0, head_cmd.count};
                end
            end
            ST_RUN: begin
                if (OutReady) begin
                    if (!is_last) begin
                        data_d   = next_elem(data_q, stride_q);
                        remain_d = remain_q - REMAIN_ONE;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next command with no idle bubble.
                        fifo_pop = 1'b1;
                        data_d   = head_cmd.start;
                        stride_d = head_cmd.stride;
                        remain_d = (head_cmd.count == '0) ? FULL_COUNT : {1'b0, head_cmd.count};
                    end else begin
                        state_d  = ST_IDLE;
                        remain_d = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            stride_q <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            stride_q <= stride_d;
            remain_q <= remain_d;
        end
    end

    assign OutValid  = (state_q == ST_RUN);
    assign OutLast   = OutValid && is_last;
    assign DataOut   = data_q;
    assign IsFull    = fifo_full;
    assign LoadReady = !fifo_full;
    assign IsEmpty   = fifo_empty && !OutValid;
    assign DbgState  = (state_q == ST_RUN);

endmodule

// File: tb/tb_seqstream.sv
// Directed bench for seqstream: a scoreboard queue of {last, data} is filled as
// commands are offered and drained as elements transfer.
module tb_seqstream;
    import seqstream_pkg::*;

    localparam int W = 8;
    localparam int C = 4;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         LoadValid;
    logic         LoadReady;
    logic [W-1:0] Start;
    logic [W-1:0] Stride;
    logic [C-1:0] Count;
    logic [W-1:0] DataOut;
    logic         OutValid;
    logic         OutReady;
    logic         OutLast;
    logic         IsFull;
    logic         IsEmpty;
    logic         DbgState;

    int           n_checks = 0;
    int           n_pass = 0;
    logic [W:0]   exp_q[$];
    logic         accepted;
    logic [W-1:0] prev_data;

    always #5 Clk = ~Clk;

    seqstream dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .LoadValid (LoadValid),
        .LoadReady (LoadReady),
        .Start     (Start),
        .Stride    (Stride),
        .Count     (Count),
        .DataOut   (DataOut),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .OutLast   (OutLast),
        .IsFull    (IsFull),
        .IsEmpty   (IsEmpty),
        .DbgState  (DbgState)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push_exp(input cmd_t c);
        int n;
        int v;
        int sst;
        n   = (c.count == '0) ? (1 << C) : int'(c.count);
        v   = int'(c.start);
        sst = $signed(c.stride);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1), v[W-1:0]});
`ifdef SEQSTREAM_SATURATE_EN
            v = v + sst;
            if (v < 0) v = 0;
            if (v > (1 << W) - 1) v = (1 << W) - 1;
`else
            v = (v + int'(c.stride)) % (1 << W);
`endif
        end
    endtask

    task automatic drive_cmd(input cmd_t c);
        push_exp(c);
        Start     = c.start;
        Stride    = c.stride;
        Count     = c.count;
        LoadValid = 1'b1;
    endtask

    // One clock: observe the handshakes the coming edge will see, then step past it.
    task automatic tick();
        logic [W:0] exp_e;
        @(negedge Clk);
        accepted = LoadValid && LoadReady && !Reset;
        if (OutValid === 1'b1 && OutReady === 1'b1 && Reset !== 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_elem", 32'(OutValid), 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("elem", 32'({OutLast, DataOut}), 32'(exp_e));
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_valid(input int bound, input string tag);
        int k;
        k = 0;
        while (OutValid !== 1'b1 && k < bound) begin
            tick();
            k++;
        end
        check(tag, 32'(OutValid), 32'd1);
    endtask

    task automatic drain(input int bound, input string tag);
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < bound) begin
            tick();
            k++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        Reset     = 1'b1;
        LoadValid = 1'b0;
        OutReady  = 1'b1;
        Start     = '0;
        Stride    = '0;
        Count     = '0;
        tick();
        tick();
        Reset = 1'b0;

        check("rst_dataout",   32'(DataOut),   32'd0);
        check("rst_outvalid",  32'(OutValid),  32'd0);
        check("rst_outlast",   32'(OutLast),   32'd0);
        check("rst_isfull",    32'(IsFull),    32'd0);
        check("rst_isempty",   32'(IsEmpty),   32'd1);
        check("rst_loadready", 32'(LoadReady), 32'd1);
        check("rst_state",     32'(DbgState),  32'd0);

        // Basic stream and two-edge latency from accept to OutValid.
        drive_cmd('{start: 8'd10, stride: 8'd3, count: 4'd4});
        tick();
        check("t1_accept", 32'(accepted), 32'd1);
        LoadValid = 1'b0;
        check("t1_lat1_valid", 32'(OutValid), 32'd0);
        tick();
        check("t1_lat2_valid", 32'(OutValid), 32'd1);
        check("t1_first", 32'(DataOut), 32'd10);
        check("t1_state_run", 32'(DbgState), 32'd1);
        repeat (4) tick();
        check("t1_drained", 32'(exp_q.size()), 32'd0);
        check("t1_idle_valid", 32'(OutValid), 32'd0);
        check("t1_idle_empty", 32'(IsEmpty), 32'd1);

        // Negative stride: wraps to 255 or clamps to 0.
        drive_cmd('{start: 8'd5, stride: 8'hFE, count: 4'd4});
        tick();
        check("t2_accept", 32'(accepted), 32'd1);
        LoadValid = 1'b0;
        wait_valid(5, "t2_valid");
        check("t2_first", 32'(DataOut), 32'd5);
        drain(16, "t2_drained");
        check("t2_idle_valid", 32'(OutValid), 32'd0);

        // Three commands back to back: queue fills, then chains without bubbles.
        drive_cmd('{start: 8'd20, stride: 8'd1, count: 4'd3});
        tick();
        check("t3_accept1", 32'(accepted), 32'd1);
        drive_cmd('{start: 8'd40, stride: 8'd2, count: 4'd3});
        tick();
        check("t3_accept2", 32'(accepted), 32'd1);
        drive_cmd('{start: 8'd60, stride: 8'd4, count: 4'd3});
        tick();
        check("t3_accept3", 32'(accepted), 32'd1);
        LoadValid = 1'b0;
        check("t3_isfull", 32'(IsFull), 32'd1);
        check("t3_loadready_low", 32'(LoadReady), 32'd0);
        tick();
        check("t3_loadready_still_low", 32'(LoadReady), 32'd0);
        tick();
        check("t3_loadready_back", 32'(LoadReady), 32'd1);
        check("t3_second_start", 32'(DataOut), 32'd40);
        begin
            int k;
            k = 0;
            while (exp_q.size() > 0 && k < 20) begin
                check("t3_no_bubble", 32'(OutValid), 32'd1);
                tick();
                k++;
            end
        end
        check("t3_drained", 32'(exp_q.size()), 32'd0);
        check("t3_idle_valid", 32'(OutValid), 32'd0);
        check("t3_idle_empty", 32'(IsEmpty), 32'd1);

        // Consumer stalls mid-stream: outputs hold, nothing lost or repeated.
        drive_cmd('{start: 8'd100, stride: 8'd7, count: 4'd6});
        tick();
        LoadValid = 1'b0;
        wait_valid(5, "t4_valid");
        tick();
        prev_data = DataOut;
        OutReady  = 1'b0;
        tick();
        check("t4_stall1_data", 32'(DataOut), 32'(prev_data));
        check("t4_stall1_valid", 32'(OutValid), 32'd1);
        tick();
        check("t4_stall2_data", 32'(DataOut), 32'(prev_data));
        check("t4_stall2_valid", 32'(OutValid), 32'd1);
        OutReady = 1'b1;
        drain(20, "t4_drained");
        check("t4_idle_valid", 32'(OutValid), 32'd0);

        // Count of zero means sixteen elements.
        drive_cmd('{start: 8'd250, stride: 8'd1, count: 4'd0});
        tick();
        LoadValid = 1'b0;
        wait_valid(5, "t5_valid");
        drain(40, "t5_drained");
        check("t5_idle_valid", 32'(OutValid), 32'd0);

        // Reset on the seventh element wins over a transfer and a new load.
        drive_cmd('{start: 8'd0, stride: 8'd1, count: 4'd0});
        tick();
        LoadValid = 1'b0;
        wait_valid(5, "t6_valid");
        repeat (6) tick();
        check("t6_seventh", 32'(DataOut), 32'd6);
        Reset     = 1'b1;
        Start     = 8'd77;
        Stride    = 8'd1;
        Count     = 4'd1;
        LoadValid = 1'b1;
        tick();
        Reset     = 1'b0;
        LoadValid = 1'b0;
        exp_q.delete();
        check("t6_rst_valid", 32'(OutValid), 32'd0);
        check("t6_rst_empty", 32'(IsEmpty), 32'd1);
        check("t6_rst_data", 32'(DataOut), 32'd0);
        check("t6_rst_last", 32'(OutLast), 32'd0);
        check("t6_rst_loadready", 32'(LoadReady), 32'd1);
        repeat (5) tick();
        check("t6_quiet_valid", 32'(OutValid), 32'd0);
        check("t6_quiet_empty", 32'(IsEmpty), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
